// File: rtl/ram64k_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port 64KB RAM
// between two valid/ack requesters, returning read data with a one-cycle ack.
module ram64k_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ack,
  output logic [7:0]  req0_rdata,

  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ack,
  output logic [7:0]  req1_rdata,

  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_in,
  output logic        ram_we,
  input  logic [7:0]  ram_data_out,

  output logic        busy,
  output logic        gnt_id
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("ram64k_arbiter: RD_LAT must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       ptr;
  logic       win_id;

  // The pointer requester wins when it is asking; otherwise the other one.
  assign win_id = ptr ? req1_valid : ~req0_valid;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking assignments would create
  // order-dependent behaviour between the state and its outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      ram_we      <= 1'b0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
      busy        <= 1'b0;
      gnt_id      <= 1'b0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            ram_address <= win_id ? req1_addr  : req0_addr;
            ram_data_in <= win_id ? req1_wdata : req0_wdata;
            ram_we      <= win_id ? req1_we    : req0_we;
            gnt_id      <= win_id;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else begin
            ram_we <= 1'b0;
          end
        end

        // The RAM samples address/data/we on the edge leaving this state.
        ISSUE: begin
          ram_we <= 1'b0;
          if (ram_we) begin
            state <= ACK;
          end else begin
            cnt   <= 3'(RD_LAT - 1);
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == 3'd0) begin
            if (gnt_id) req1_rdata <= ram_data_out;
            else        req0_rdata <= ram_data_out;
            state <= ACK;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        ACK: begin
          if (gnt_id) req1_ack <= 1'b1;
          else        req0_ack <= 1'b1;
          ptr   <= ~gnt_id;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram64k_arbiter.sv
// Directed bench for ram64k_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=3, each with its own behavioural RAM; requester inputs are steered.
module tb_ram64k_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared requester stimulus, steered to one DUT by use3
  logic        use3;
  logic        v0, we0, v1, we1;
  logic [15:0] a0, a1;
  logic [7:0]  d0, d1;

  // RD_LAT=1 instance
  logic        d_ack0, d_ack1, d_ram_we, d_busy, d_gnt;
  logic [7:0]  d_rd0, d_rd1, d_din, d_dout;
  logic [15:0] d_addr;

  // RD_LAT=3 instance
  logic        t_ack0, t_ack1, t_ram_we, t_busy, t_gnt;
  logic [7:0]  t_rd0, t_rd1, t_din, t_dout;
  logic [15:0] t_addr;

  wire       ack0  = use3 ? t_ack0 : d_ack0;
  wire       ack1  = use3 ? t_ack1 : d_ack1;
  wire [7:0] rd0   = use3 ? t_rd0  : d_rd0;
  wire [7:0] rd1   = use3 ? t_rd1  : d_rd1;
  wire       busy  = use3 ? t_busy : d_busy;
  wire       gnt   = use3 ? t_gnt  : d_gnt;

  ram64k_arbiter #(.RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0 & ~use3), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req0_ack(d_ack0), .req0_rdata(d_rd0),
    .req1_valid(v1 & ~use3), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .req1_ack(d_ack1), .req1_rdata(d_rd1),
    .ram_address(d_addr), .ram_data_in(d_din), .ram_we(d_ram_we),
    .ram_data_out(d_dout), .busy(d_busy), .gnt_id(d_gnt)
  );

  ram64k_arbiter #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0 & use3), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req0_ack(t_ack0), .req0_rdata(t_rd0),
    .req1_valid(v1 & use3), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .req1_ack(t_ack1), .req1_rdata(t_rd1),
    .ram_address(t_addr), .ram_data_in(t_din), .ram_we(t_ram_we),
    .ram_data_out(t_dout), .busy(t_busy), .gnt_id(t_gnt)
  );

  // Behavioural RAMs: data_out is registered at the address-sampling edge,
  // plus RD_LAT-1 further pipeline stages.
  logic [7:0] mem  [65536];
  logic [7:0] mem3 [65536];
  logic [7:0] p3 [3];
  int         we_cnt = 0;
  logic [15:0] last_waddr;
  logic [7:0]  last_wdata;

  always @(posedge clk) begin
    if (d_ram_we) begin
      mem[d_addr] <= d_din;
      we_cnt      <= we_cnt + 1;
      last_waddr  <= d_addr;
      last_wdata  <= d_din;
    end
    d_dout <= mem[d_addr];
  end

  always @(posedge clk) begin
    if (t_ram_we) mem3[t_addr] <= t_din;
    p3[0] <= mem3[t_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign t_dout = p3[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on port p (called at posedge+1) and wait for its ack.
  task automatic do_cmd(input bit p, input bit we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input int exp_lat, input string tag);
    int n;
    bit got;
    if (!p) begin v0 = 1'b1; we0 = we; a0 = addr; d0 = wd; end
    else    begin v1 = 1'b1; we1 = we; a1 = addr; d1 = wd; end
    tick();
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (p ? ack0 : ack1) check({tag, "_wrong_ack"}, 1, 0);
      if (p ? ack1 : ack0) got = 1'b1;
    end
    check({tag, "_lat"}, got ? n : -1, exp_lat);
    if (!we) check({tag, "_rdata"}, p ? rd1 : rd0, exp_rd);
    if (!p) v0 = 1'b0; else v1 = 1'b0;
    tick();
    check({tag, "_ack_width"}, p ? ack1 : ack0, 0);
  endtask

  int       order[$];
  int       gseq[$];
  int       rem0, rem1, n, wc;
  bit       prev_busy;
  int       exp_g;

  initial begin
    use3 = 1'b0;
    mem[16'h0000]  = 8'h11;
    mem[16'h0010]  = 8'h22;
    mem3[16'h0000] = 8'h11;

    // Reset with both requesters asking: req0 CD@0002, req1 EF@0003
    rst_n = 1'b0;
    v0 = 1'b1; we0 = 1'b1; a0 = 16'h0002; d0 = 8'hCD;
    v1 = 1'b1; we1 = 1'b1; a1 = 16'h0003; d1 = 8'hEF;
    tick(); tick();
    check("rst_ram_we", d_ram_we, 0);
    check("rst_acks",   {d_ack0, d_ack1}, 0);
    check("rst_busy",   d_busy, 0);
    rst_n = 1'b1;
    tick();
    check("first_gnt",   d_gnt, 0);
    check("first_we",    d_ram_we, 1);
    check("first_addr",  d_addr, 16'h0002);
    n = 0;
    while (order.size() < 2 && n < 40) begin
      tick();
      n++;
      if (ack0 && ack1) check("two_acks", 1, 0);
      if (ack0) begin order.push_back(0); v0 = 1'b0; if (order.size() == 1) check("c0_lat", n, 2); end
      if (ack1) begin order.push_back(1); v1 = 1'b0; end
    end
    check("cont_count",  order.size(), 2);
    check("cont_first",  order.size() > 0 ? order[0] : 9, 0);
    check("cont_second", order.size() > 1 ? order[1] : 9, 1);
    tick();
    do_cmd(0, 0, 16'h0002, 8'h00, 8'hCD, 3, "rb2");
    do_cmd(1, 0, 16'h0003, 8'h00, 8'hEF, 3, "rb3");

    // Single write/read by req0
    wc = we_cnt;
    do_cmd(0, 1, 16'h0001, 8'hAB, 8'h00, 2, "wr1");
    check("wr1_we_pulses", we_cnt - wc, 1);
    check("wr1_waddr",     last_waddr, 16'h0001);
    check("wr1_wdata",     last_wdata, 8'hAB);
    do_cmd(0, 0, 16'h0001, 8'h00, 8'hAB, 3, "rd1");

    // Top address via req1; a write must leave rdata alone
    do_cmd(1, 1, 16'hFFFF, 8'h5A, 8'h00, 2, "wrF");
    check("wrF_rdata_hold", d_rd1, 8'hEF);
    do_cmd(1, 0, 16'hFFFF, 8'h00, 8'h5A, 3, "rdF");
    do_cmd(1, 0, 16'h0000, 8'h00, 8'h11, 3, "rd0");

    // Fairness: both held, three writes each, re-issued on every ack
    rem0 = 3; rem1 = 3; prev_busy = 1'b0;
    v0 = 1'b1; we0 = 1'b1; a0 = 16'h0100; d0 = 8'h30;
    v1 = 1'b1; we1 = 1'b1; a1 = 16'h0200; d1 = 8'h40;
    order.delete();
    n = 0;
    while ((rem0 > 0 || rem1 > 0) && n < 100) begin
      tick();
      n++;
      if (d_busy && !prev_busy) gseq.push_back(int'(d_gnt));
      prev_busy = d_busy;
      if (ack0 && ack1) check("fair_two_acks", 1, 0);
      if (ack0) begin
        order.push_back(0); rem0--;
        if (rem0 > 0) begin a0 = a0 + 16'd1; d0 = d0 + 8'd1; end else v0 = 1'b0;
      end
      if (ack1) begin
        order.push_back(1); rem1--;
        if (rem1 > 0) begin a1 = a1 + 16'd1; d1 = d1 + 8'd1; end else v1 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    check("fair_gnt_count", gseq.size(), 6);
    check("fair_ack_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      exp_g = i % 2;
      check($sformatf("fair_gnt%0d", i), i < gseq.size()  ? gseq[i]  : 9, exp_g);
      check($sformatf("fair_ack%0d", i), i < order.size() ? order[i] : 9, exp_g);
    end
    check("fair_mem0102", mem[16'h0102], 8'h32);
    check("fair_mem0202", mem[16'h0202], 8'h42);
    tick();

    // RD_LAT = 3 instance
    use3 = 1'b1;
    do_cmd(1, 1, 16'hFFFF, 8'h5A, 8'h00, 2, "l3_wr");
    do_cmd(1, 0, 16'hFFFF, 8'h00, 8'h5A, 5, "l3_rd");
    do_cmd(1, 0, 16'h0000, 8'h00, 8'h11, 5, "l3_rd0");
    use3 = 1'b0;
    tick();

    // Reset during WAIT of a read
    v0 = 1'b1; we0 = 1'b0; a0 = 16'h0001; d0 = 8'h00;
    tick();
    tick();
    check("mid_busy_pre", d_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",  d_busy, 0);
    check("mid_rdata", d_rd0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_ack%0d", i), {d_ack0, d_ack1}, 0);
    end
    v0 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mid_no_ack_post", {d_ack0, d_ack1}, 0);

    // Reset while a write is pending in IDLE
    wc = we_cnt;
    v0 = 1'b1; we0 = 1'b1; a0 = 16'h0010; d0 = 8'h77;
    rst_n = 1'b0;
    tick(); tick();
    v0 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("pend_no_we", we_cnt - wc, 0);
    do_cmd(0, 0, 16'h0010, 8'h00, 8'h22, 3, "pend_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
